// File: rtl/timebase_pkg.sv
// timebase_pkg: lock state encoding, error counter width and the
// saturating error-count step shared by the timebase monitor files.
package timebase_pkg;

  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } lock_state_t;

  // Lock-loss counter step; holds at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/timebase_monitor_sync_meter.sv
// sync_meter: registers one active-low sync line, detects its falling and
// rising edges, counts ticks since the last fall (saturating), and latches
// the fall-to-fall period and the fall-to-rise low width.
// FALL_IS_TICK selects which period owns a tick that coincides with a fall:
//   0 - the tick closes the old period (period = count + tick, restart at 0),
//   1 - the tick opens the new period (period = count, restart at tick).
module sync_meter #(
  parameter int W            = 10,
  parameter bit FALL_IS_TICK = 1'b0
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  input  logic         sync_line,
  input  logic         tick,
  output logic         fall,
  output logic         rise,
  output logic [W-1:0] count,
  output logic [W-1:0] meas,
  output logic [W-1:0] period,
  output logic [W-1:0] width
);

  logic         sync_q;
  logic         sync_prev;
  logic [W-1:0] step;
  logic [W-1:0] restart;
  logic [W-1:0] mark;

  assign fall    = sync_prev & ~sync_q;
  assign rise    = ~sync_prev & sync_q;
  assign restart = FALL_IS_TICK ? {{(W-1){1'b0}}, tick} : '0;
  assign meas    = FALL_IS_TICK ? count : step;

  // Counter value advanced by this cycle's tick, parked at all-ones.
  always_comb begin
    step = count;
    if (tick && !(&count)) begin
      step = count + 1'b1;
    end
  end

  // Sync input pipeline, tick counter and period/width latches.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      sync_q    <= 1'b1;
      sync_prev <= 1'b1;
      count     <= '0;
      mark      <= '0;
      period    <= '0;
      width     <= '0;
    end else begin
      sync_q    <= sync_line;
      sync_prev <= sync_q;
      if (fall) begin
        count  <= restart;
        mark   <= restart;
        period <= meas;
      end else begin
        count <= step;
      end
      if (rise) begin
        width <= step - mark;
      end
    end
  end

endmodule

// File: rtl/timebase_monitor.sv
// timebase_monitor: measures video sync timing (line period, HSYNC width,
// frame length), tracks the beam position, and runs a lock FSM that only
// declares lock after a reference line and frame repeat exactly.
module timebase_monitor
  import timebase_pkg::*;
#(
  parameter int DOT_W  = 10,
  parameter int LINE_W = 10
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              HSYNC_I,
  input  logic              VSYNC_I,
  output logic [DOT_W-1:0]  X_O,
  output logic [LINE_W-1:0] Y_O,
  output logic [DOT_W-1:0]  LINE_LEN_O,
  output logic [DOT_W-1:0]  HSW_O,
  output logic [LINE_W-1:0] FRAME_LINES_O,
  output logic              LOCKED_O,
  output logic [ERR_W-1:0]  ERRCNT_O
);

  logic              h_fall;
  logic              h_rise_unused;
  logic [DOT_W-1:0]  h_count;
  logic [DOT_W-1:0]  h_meas;
  logic [DOT_W-1:0]  h_period;
  logic [DOT_W-1:0]  h_width;

  logic              v_fall;
  logic              v_rise_unused;
  logic [LINE_W-1:0] v_count;
  logic [LINE_W-1:0] v_meas;
  logic [LINE_W-1:0] v_period;
  logic [LINE_W-1:0] v_width_unused;

  lock_state_t       state;
  logic [DOT_W-1:0]  ref_period;
  logic [LINE_W-1:0] ref_frame;
  logic              first_seen;
  logic [ERR_W-1:0]  errcnt;
  logic              locked_q;

  logic              timeout;
  logic              line_bad;
  logic              frame_bad;

  // Dots: one tick per clock, the fall cycle closes the old line.
  sync_meter #(
    .W            (DOT_W),
    .FALL_IS_TICK (1'b0)
  ) u_hsync (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .sync_line (HSYNC_I),
    .tick      (1'b1),
    .fall      (h_fall),
    .rise      (h_rise_unused),
    .count     (h_count),
    .meas      (h_meas),
    .period    (h_period),
    .width     (h_width)
  );

  // Lines: one tick per HSYNC fall; a coincident HSYNC fall is line 1 of
  // the new frame, so the frame length excludes it.
  sync_meter #(
    .W            (LINE_W),
    .FALL_IS_TICK (1'b1)
  ) u_vsync (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .sync_line (VSYNC_I),
    .tick      (h_fall),
    .fall      (v_fall),
    .rise      (v_rise_unused),
    .count     (v_count),
    .meas      (v_meas),
    .period    (v_period),
    .width     (v_width_unused)
  );

  assign timeout   = &h_count;
  assign line_bad  = h_fall && (h_meas != ref_period);
  assign frame_bad = v_fall && (v_meas != ref_frame);

  // Lock FSM: capture a reference line and frame, confirm one more frame,
  // then watch for any exact mismatch or a missing HSYNC.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state      <= SEARCH;
      ref_period <= '0;
      ref_frame  <= '0;
      first_seen <= 1'b0;
      errcnt     <= '0;
      locked_q   <= 1'b0;
    end else begin
      locked_q <= (state == LOCKED);
      if (timeout) begin
        state <= SEARCH;
        if (state == LOCKED) begin
          errcnt <= err_inc(errcnt);
        end
      end else begin
        case (state)
          SEARCH: begin
            if (v_fall) begin
              state      <= ACQUIRE;
              first_seen <= 1'b0;
            end
          end
          ACQUIRE: begin
            if (first_seen && line_bad) begin
              state <= SEARCH;
            end else begin
              if (h_fall && !first_seen) begin
                ref_period <= h_meas;
                first_seen <= 1'b1;
              end
              if (v_fall && first_seen) begin
                ref_frame <= v_meas;
                state     <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (line_bad || frame_bad) begin
              state <= SEARCH;
            end else if (v_fall) begin
              state <= LOCKED;
            end
          end
          LOCKED: begin
            if (line_bad || frame_bad) begin
              state  <= SEARCH;
              errcnt <= err_inc(errcnt);
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign X_O           = h_count;
  assign Y_O           = v_count;
  assign LINE_LEN_O    = h_period;
  assign HSW_O         = h_width;
  assign FRAME_LINES_O = v_period;
  assign LOCKED_O      = locked_q;
  assign ERRCNT_O      = errcnt;

endmodule

// File: tb/tb_timebase_monitor.sv
// tb_timebase_monitor: drives whole frames described by a table of records
// and compares the measured timing, lock and error outputs against the
// hand-computed values stored in each record; timeout, mid-frame reset and
// error saturation are driven as separate sequences.
module tb_timebase_monitor;

  logic       CLK_I;
  logic       RST_I;
  logic       HSYNC_I;
  logic       VSYNC_I;
  logic [9:0] X_O;
  logic [9:0] Y_O;
  logic [9:0] LINE_LEN_O;
  logic [9:0] HSW_O;
  logic [9:0] FRAME_LINES_O;
  logic       LOCKED_O;
  logic [7:0] ERRCNT_O;

  typedef struct {
    int dots;
    int hsw;
    int lines;
    int vlines;
    int bad_idx;
    int bad_len;
    int exp_len;
    int exp_hsw;
    int exp_frame;
    int exp_lk_start;
    int exp_lk_end;
    int exp_err;
  } frame_t;

  int     total;
  int     bad;
  int     prev_locked;
  frame_t tbl[14];

  timebase_monitor #(
    .DOT_W  (10),
    .LINE_W (10)
  ) dut (
    .CLK_I         (CLK_I),
    .RST_I         (RST_I),
    .HSYNC_I       (HSYNC_I),
    .VSYNC_I       (VSYNC_I),
    .X_O           (X_O),
    .Y_O           (Y_O),
    .LINE_LEN_O    (LINE_LEN_O),
    .HSW_O         (HSW_O),
    .FRAME_LINES_O (FRAME_LINES_O),
    .LOCKED_O      (LOCKED_O),
    .ERRCNT_O      (ERRCNT_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  function automatic frame_t mk_frame(int dots, int hsw, int lines, int vlines,
                                      int bad_idx, int bad_len, int exp_len,
                                      int exp_hsw, int exp_frame, int exp_lk_start,
                                      int exp_lk_end, int exp_err);
    frame_t f;
    f.dots         = dots;
    f.hsw          = hsw;
    f.lines        = lines;
    f.vlines       = vlines;
    f.bad_idx      = bad_idx;
    f.bad_len      = bad_len;
    f.exp_len      = exp_len;
    f.exp_hsw      = exp_hsw;
    f.exp_frame    = exp_frame;
    f.exp_lk_start = exp_lk_start;
    f.exp_lk_end   = exp_lk_end;
    f.exp_err      = exp_err;
    return f;
  endfunction

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_x"},     int'(X_O), 0);
    checkOutput({tag, "_y"},     int'(Y_O), 0);
    checkOutput({tag, "_len"},   int'(LINE_LEN_O), 0);
    checkOutput({tag, "_hsw"},   int'(HSW_O), 0);
    checkOutput({tag, "_frame"}, int'(FRAME_LINES_O), 0);
    checkOutput({tag, "_lock"},  int'(LOCKED_O), 0);
    checkOutput({tag, "_err"},   int'(ERRCNT_O), 0);
  endtask

  // One frame: HSYNC and VSYNC fall together on its first dot.
  task automatic applyStimulus(input frame_t f, input string tag);
    int len;
    for (int ln = 0; ln < f.lines; ln++) begin
      len = (ln == f.bad_idx) ? f.bad_len : f.dots;
      for (int d = 0; d < len; d++) begin
        HSYNC_I = (d < f.hsw) ? 1'b0 : 1'b1;
        VSYNC_I = (ln < f.vlines) ? 1'b0 : 1'b1;
        tick();
        if (ln == 0 && d == 1) begin
          checkOutput({tag, "_start_x"}, int'(X_O), 0);
          checkOutput({tag, "_start_y"}, int'(Y_O), 1);
          checkOutput({tag, "_lock_pre"}, int'(LOCKED_O), prev_locked);
        end
        if (ln == 0 && d == 2) begin
          checkOutput({tag, "_lock_start"}, int'(LOCKED_O), f.exp_lk_start);
        end
      end
    end
    checkOutput({tag, "_len"},   int'(LINE_LEN_O), f.exp_len);
    checkOutput({tag, "_hsw"},   int'(HSW_O), f.exp_hsw);
    checkOutput({tag, "_frame"}, int'(FRAME_LINES_O), f.exp_frame);
    checkOutput({tag, "_lock"},  int'(LOCKED_O), f.exp_lk_end);
    checkOutput({tag, "_err"},   int'(ERRCNT_O), f.exp_err);
    prev_locked = f.exp_lk_end;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int err;
    total       = 0;
    bad         = 0;
    prev_locked = 0;

    // Full-size lines, 3-line frames: lock, one long line, re-lock.
    tbl[0]  = mk_frame(795, 94, 3, 2, -1, 0,   795, 94, 0, 0, 0, 0);
    tbl[1]  = mk_frame(795, 94, 3, 2, -1, 0,   795, 94, 3, 0, 0, 0);
    tbl[2]  = mk_frame(795, 94, 3, 2, -1, 0,   795, 94, 3, 1, 1, 0);
    tbl[3]  = mk_frame(795, 94, 3, 2, 1, 796,  796, 94, 3, 1, 0, 1);
    tbl[4]  = mk_frame(795, 94, 3, 2, -1, 0,   795, 94, 3, 0, 0, 1);
    tbl[5]  = mk_frame(795, 94, 3, 2, -1, 0,   795, 94, 3, 0, 0, 1);
    tbl[6]  = mk_frame(795, 94, 3, 2, -1, 0,   795, 94, 3, 1, 1, 1);
    // After the timeout: one 526-line frame, then lock on 4-line frames.
    tbl[7]  = mk_frame(8, 2, 526, 2, -1, 0,    8, 2, 3,   0, 0, 2);
    tbl[8]  = mk_frame(8, 2, 4, 2, -1, 0,      8, 2, 526, 0, 0, 2);
    tbl[9]  = mk_frame(8, 2, 4, 2, -1, 0,      8, 2, 4,   0, 0, 2);
    tbl[10] = mk_frame(8, 2, 4, 2, -1, 0,      8, 2, 4,   1, 1, 2);
    // After the mid-frame reset: full re-lock from scratch.
    tbl[11] = mk_frame(8, 2, 4, 2, -1, 0,      8, 2, 0, 0, 0, 0);
    tbl[12] = mk_frame(8, 2, 4, 2, -1, 0,      8, 2, 4, 0, 0, 0);
    tbl[13] = mk_frame(8, 2, 4, 2, -1, 0,      8, 2, 4, 1, 1, 0);

    RST_I   = 1'b1;
    HSYNC_I = 1'b1;
    VSYNC_I = 1'b1;
    repeat (3) tick();
    checkAllZero("reset");
    RST_I = 1'b0;
    repeat (3) tick();

    for (int i = 0; i <= 6; i++) begin
      applyStimulus(tbl[i], $sformatf("frame%0d", i));
    end

    // HSYNC stops while locked: dot counter saturates, lock drops.
    HSYNC_I = 1'b1;
    VSYNC_I = 1'b1;
    for (int t = 1; t <= 1100; t++) begin
      tick();
      if (t == 200) begin
        checkOutput("hold_still_locked", int'(LOCKED_O), 1);
      end
    end
    checkOutput("timeout_x",    int'(X_O), 1023);
    checkOutput("timeout_lock", int'(LOCKED_O), 0);
    checkOutput("timeout_err",  int'(ERRCNT_O), 2);
    prev_locked = 0;

    for (int i = 7; i <= 10; i++) begin
      applyStimulus(tbl[i], $sformatf("frame%0d", i));
    end

    // Reset pulse a few dots into a locked frame, between clock edges.
    HSYNC_I = 1'b0;
    VSYNC_I = 1'b0;
    repeat (5) tick();
    checkOutput("rst_pre_lock", int'(LOCKED_O), 1);
    checkOutput("rst_pre_err",  int'(ERRCNT_O), 2);
    #2;
    RST_I = 1'b1;
    #1;
    checkAllZero("midreset");
    HSYNC_I = 1'b1;
    VSYNC_I = 1'b1;
    repeat (2) tick();
    RST_I = 1'b0;
    repeat (3) tick();
    prev_locked = 0;

    for (int i = 11; i <= 13; i++) begin
      applyStimulus(tbl[i], $sformatf("frame%0d", i));
    end

    // 300 lock losses, each followed by a clean three-frame re-lock.
    for (int i = 0; i < 300; i++) begin
      err = (i + 1 > 255) ? 255 : i + 1;
      applyStimulus(mk_frame(4, 1, 2, 1, 0, 5,  5, 1, (i == 0) ? 4 : 2, 1, 0, err), "loss_bad");
      applyStimulus(mk_frame(4, 1, 2, 1, -1, 0, 4, 1, 2, 0, 0, err), "loss_g1");
      applyStimulus(mk_frame(4, 1, 2, 1, -1, 0, 4, 1, 2, 0, 0, err), "loss_g2");
      applyStimulus(mk_frame(4, 1, 2, 1, -1, 0, 4, 1, 2, 1, 1, err), "loss_g3");
    end
    checkOutput("err_saturated", int'(ERRCNT_O), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timebase_monitor.md
TIMEBASE_MONITOR -- requirements
Module: timebase_monitor

Interface
REQ-001 SHALL have parameter DOT_W, default 10: dot-counter and line-length width.
REQ-002 SHALL have parameter LINE_W, default 10: line-counter and frame-length width.
REQ-003 SHALL have port CLK_I, input, 1: the only clock, the dot clock (25 MHz); all logic on the rising edge.
REQ-004 SHALL have port RST_I, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port HSYNC_I, input, 1: horizontal sync, active-low pulse, synchronous to CLK_I.
REQ-006 SHALL have port VSYNC_I, input, 1: vertical sync, active-low pulse, synchronous to CLK_I.
REQ-007 SHALL have port X_O, output, DOT_W: dots elapsed since the last HSYNC falling edge.
REQ-008 SHALL have port Y_O, output, LINE_W: lines elapsed since the last VSYNC falling edge.
REQ-009 SHALL have port LINE_LEN_O, output, DOT_W: last measured line period in dots.
REQ-010 SHALL have port HSW_O, output, DOT_W: last measured HSYNC low width in dots.
REQ-011 SHALL have port FRAME_LINES_O, output, LINE_W: last measured frame length in lines.
REQ-012 SHALL have port LOCKED_O, output, 1: high when timing is stable.
REQ-013 SHALL have port ERRCNT_O, output, 8: count of lock losses, saturating.

Function
REQ-014 SHALL register HSYNC_I and VSYNC_I once; a fall is previous-registered=1 and current-registered=0; a rise is the converse.
REQ-015 SHALL clear the dot counter to 0 on an HSYNC fall, increment it otherwise, and saturate it at all-ones.
REQ-016 SHALL latch LINE_LEN_O = dot counter + 1 on an HSYNC fall; output is valid 2 cycles after the HSYNC_I edge.
REQ-017 SHALL latch HSW_O = dot counter + 1 − (dot count at the last fall) on an HSYNC rise.
REQ-018 SHALL clear the line counter on a VSYNC fall, increment it on each HSYNC fall otherwise, and saturate it at all-ones.
REQ-019 SHALL latch FRAME_LINES_O = line counter on a VSYNC fall.
REQ-020 SHALL, when HSYNC and VSYNC fall in the same cycle, latch the frame first and count that HSYNC fall as line 1 of the new frame.
REQ-021 SHALL implement a lock FSM with states SEARCH, ACQUIRE, VERIFY, LOCKED.
REQ-022 SEARCH: on a VSYNC fall, go to ACQUIRE; clear the first-line flag.
REQ-023 ACQUIRE: store the first full line period as the reference period; any later line period differing from it goes to SEARCH; on a VSYNC fall, store FRAME_LINES as the reference and go to VERIFY.
REQ-024 VERIFY: every line must equal the reference period; the next VSYNC fall with an equal line count goes to LOCKED; any mismatch goes to SEARCH.
REQ-025 LOCKED: a line-period mismatch, a frame-count mismatch, or dot-counter saturation (timeout) SHALL go to SEARCH and increment ERRCNT_O, saturating at 255.
REQ-026 SHALL drive LOCKED_O high only in LOCKED, registered, one cycle after the state transition.
REQ-027 SHALL apply dot-counter saturation in any state to force SEARCH; only an exit from LOCKED counts as an error.
REQ-028 SHALL compare periods exactly, with no tolerance.

Reset
REQ-029 SHALL, on RST_I, asynchronously force SEARCH and set all counters and outputs to 0, and the sync registers to 1 (idle).
REQ-030 SHALL, on RST_I asserted mid-frame, discard all references; re-lock requires a full SEARCH→LOCKED sequence.

Structure
REQ-031 SHALL keep the FSM state encoding and the ERRCNT width in a shared package timebase_pkg.
REQ-032 SHALL implement the edge detection plus period/width measurement as one sub-module, sync_meter, instanced once for H and once for V.

Verification
REQ-033 Stimulus: ideal timing of 795-dot lines, HSYNC low for 94 dots, 526-line frames, VSYNC low for 2 lines. Response: LOCKED_O high 1 cycle after the third VSYNC fall; LINE_LEN_O=795, HSW_O=94, FRAME_LINES_O=526.
REQ-034 Stimulus: while locked, one line of 796 dots. Response: LOCKED_O low; ERRCNT_O=1; re-lock after 3 clean VSYNC falls.
REQ-035 Stimulus: HSYNC_I held high for 1100 cycles while locked. Response: timeout; SEARCH; ERRCNT_O increments; X_O holds at 1023.
REQ-036 Stimulus: HSYNC and VSYNC fall in the same cycle. Response: Y_O=1 after that cycle; FRAME_LINES_O equals the prior count.
REQ-037 Stimulus: RST_I pulsed mid-frame while locked. Response: all outputs 0 immediately, asynchronously; ERRCNT_O=0; lock again after 3 VSYNC falls.
REQ-038 Stimulus: 300 forced lock losses. Response: ERRCNT_O saturates at 255.
